// File: rtl/mem_mmio_bus.sv
// Word-addressed RAM plus memory-mapped UART TX FIFO, status and cycle counter.
// Reads are combinational; an 8N1 transmitter drains the FIFO onto tx.
module mem_mmio_bus #(
    parameter int unsigned MEM_WORDS    = 4096,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic [31:0] rdata,
    output logic        tx
);

    localparam int unsigned AW  = $clog2(MEM_WORDS);
    localparam int unsigned FAW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    // Address decode; the byte offset bits are ignored throughout
    logic          sel_ram;
    logic          sel_txdata;
    logic          sel_status;
    logic          sel_cycles;
    logic [AW-1:0] ram_idx;
    logic [1:0]    unused_addr;

    assign sel_ram     = (address[31:28] == 4'h0);
    assign sel_txdata  = (address[31:2] == 30'h0400_0000);
    assign sel_status  = (address[31:2] == 30'h0400_0001);
    assign sel_cycles  = (address[31:2] == 30'h0400_0002);
    assign ram_idx     = address[AW+1:2];
    assign unused_addr = address[1:0];

    // RAM storage, not cleared by reset
    logic [31:0] mem [MEM_WORDS];

    // RAM write port
    always_ff @(posedge clk) begin
        if (we && sel_ram) begin
            mem[ram_idx] <= wdata;
        end
    end

    // TX FIFO: pointers carry one extra wrap bit to tell full from empty
    logic [7:0]   fifo_mem [FIFO_DEPTH];
    logic [FAW:0] wr_ptr;
    logic [FAW:0] rd_ptr;
    logic [FAW:0] fifo_count;
    logic         fifo_full;
    logic         fifo_empty;
    logic         push;
    logic         overflow;
    logic         pop_c;
    logic [3:0]   count_sat;

    assign fifo_count = wr_ptr - rd_ptr;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[FAW] != rd_ptr[FAW]) &&
                        (wr_ptr[FAW-1:0] == rd_ptr[FAW-1:0]);
    assign push       = we && sel_txdata && !fifo_full;

    // Status count field saturates at 15 for deep FIFOs
    always_comb begin
        count_sat = 4'(fifo_count);
        if (32'(fifo_count) > 32'd15) begin
            count_sat = 4'hF;
        end
    end

    // FIFO data storage
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[FAW-1:0]] <= wdata[7:0];
        end
    end

    // FIFO pointers and sticky overflow flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (FAW+1)'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + (FAW+1)'(1);
            end
            if (we && sel_txdata && fifo_full) begin
                overflow <= 1'b1;
            end else if (we && sel_status && wdata[3]) begin
                overflow <= 1'b0;
            end
        end
    end

    // Transmitter state
    tx_state_t     state;
    tx_state_t     state_next;
    logic [7:0]    shift;
    logic [7:0]    shift_next;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_next;
    logic [CW-1:0] clk_cnt;
    logic [CW-1:0] cnt_next;
    logic          bit_end;
    logic          busy;

    assign bit_end = (clk_cnt == CW'(CLKS_PER_BIT - 1));
    assign busy    = (state != IDLE);

    // Transmitter next-state and FIFO pop decision
    always_comb begin
        state_next = state;
        shift_next = shift;
        bit_next   = bit_idx;
        cnt_next   = clk_cnt + CW'(1);
        pop_c      = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (!fifo_empty) begin
                    pop_c      = 1'b1;
                    shift_next = fifo_mem[rd_ptr[FAW-1:0]];
                    bit_next   = '0;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_next   = '0;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_next = '0;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_next   = bit_idx + 3'd1;
                        shift_next = {1'b0, shift[7:1]};
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_next = '0;
                    if (!fifo_empty) begin
                        pop_c      = 1'b1;
                        shift_next = fifo_mem[rd_ptr[FAW-1:0]];
                        bit_next   = '0;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Transmitter registers; tx is registered from the current state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            shift   <= '0;
            bit_idx <= '0;
            clk_cnt <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_next;
            shift   <= shift_next;
            bit_idx <= bit_next;
            clk_cnt <= cnt_next;
            case (state)
                START:   tx <= 1'b0;
                DATA:    tx <= shift[0];
                default: tx <= 1'b1;
            endcase
        end
    end

    // Free-running cycle counter, loadable by a write
    logic [31:0] cycles;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycles <= '0;
        end else if (we && sel_cycles) begin
            cycles <= wdata;
        end else begin
            cycles <= cycles + 32'd1;
        end
    end

    // Combinational read mux; TXDATA and unmapped addresses read 0
    always_comb begin
        rdata = '0;
        if (sel_ram) begin
            rdata = mem[ram_idx];
        end else if (sel_status) begin
            rdata = {24'd0, count_sat, overflow, busy, fifo_empty, fifo_full};
        end else if (sel_cycles) begin
            rdata = cycles;
        end
    end

endmodule
